// File: rtl/cache_config_pkg.sv
// Shared LLC/bus definitions: operation and snoop encodings, line geometry, combine helper.
package cache_config_pkg;

    localparam int unsigned ADDR_W           = 32;
    localparam int unsigned LINE_OFFSET_BITS = 6;
    localparam logic [ADDR_W-1:0] LINE_MASK  = ~ADDR_W'((32'd1 << LINE_OFFSET_BITS) - 32'd1);

    typedef enum logic [2:0] {
        OP_NOP        = 3'd0,
        OP_READ       = 3'd1,
        OP_WRITE      = 3'd2,
        OP_INVALIDATE = 3'd3,
        OP_RWIM       = 3'd4
    } bus_op_t;

    typedef enum logic [1:0] {
        SNP_NOHIT = 2'd0,
        SNP_HIT   = 2'd1,
        SNP_HITM  = 2'd2
    } snoop_result_t;

    // Latched bus operation payload
    typedef struct packed {
        bus_op_t           op;
        logic [ADDR_W-1:0] addr;
    } bus_req_t;

    // Strongest of two snoop results (HITM > HIT > NOHIT); encoding 3 ranks as NOHIT
    function automatic snoop_result_t snoop_max(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] na;
        logic [1:0] nb;
        na = (a == 2'd3) ? 2'd0 : a;
        nb = (b == 2'd3) ? 2'd0 : b;
        return snoop_result_t'((na > nb) ? na : nb);
    endfunction

endpackage

// File: rtl/bus_op_responder_combiner.sv
// snoop_combiner: tracks which agents have reported and folds their results into one.
module snoop_combiner
    import cache_config_pkg::*;
#(
    parameter int unsigned NUM_SNOOPERS = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear_i,
    input  logic                        fold_i,
    input  logic [NUM_SNOOPERS-1:0]     snp_valid_i,
    input  logic [2*NUM_SNOOPERS-1:0]   snp_result_i,
    output logic                        all_received_c_o,
    output snoop_result_t               combined_c_o
);

    logic [NUM_SNOOPERS-1:0] mask_q;
    snoop_result_t           acc_q;
    logic [NUM_SNOOPERS-1:0] new_c;
    snoop_result_t           acc_c;

    // First strobe per agent only; view includes this cycle's strobes
    always_comb begin
        new_c = snp_valid_i & ~mask_q & {NUM_SNOOPERS{fold_i}};
        acc_c = acc_q;
        for (int k = 0; k < int'(NUM_SNOOPERS); k++) begin
            if (new_c[k]) begin
                acc_c = snoop_max(acc_c, snp_result_i[2*k +: 2]);
            end
        end
        all_received_c_o = &(mask_q | new_c);
        combined_c_o     = acc_c;
    end

    // Received mask and accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
            acc_q  <= SNP_NOHIT;
        end else if (clear_i) begin
            mask_q <= '0;
            acc_q  <= SNP_NOHIT;
        end else if (fold_i) begin
            mask_q <= mask_q | new_c;
            acc_q  <= acc_c;
        end
    end

endmodule

// File: rtl/bus_op_responder.sv
// bus_op_responder: issues one LLC bus operation, gathers snoops, waits for HITM writeback, responds.
module bus_op_responder
    import cache_config_pkg::*;
#(
    parameter int unsigned NUM_SNOOPERS  = 3,
    parameter int unsigned SNOOP_TIMEOUT = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [2:0]                  req_op,
    input  logic [31:0]                 req_addr,
    output logic                        rsp_valid,
    output logic [1:0]                  rsp_snoop,
    output logic                        rsp_timeout,
    output logic                        bus_valid,
    output logic [2:0]                  bus_op,
    output logic [31:0]                 bus_addr,
    input  logic [NUM_SNOOPERS-1:0]     snp_valid,
    input  logic [2*NUM_SNOOPERS-1:0]   snp_result,
    input  logic                        wb_valid,
    input  logic [31:0]                 wb_addr
);

    localparam int unsigned CNT_W = $clog2(SNOOP_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SNOOP_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_COLLECT = 3'd2,
        S_WAIT_WB = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    bus_req_t      req_q, req_d;
    snoop_result_t rsp_snoop_q, rsp_snoop_d;
    logic          rsp_timeout_q, rsp_timeout_d;
    logic          req_ready_q, bus_valid_q, rsp_valid_q;
    logic          clear_c, fold_c, all_received_c, wb_hit_c;
    snoop_result_t combined_c;
    bus_op_t       op_in_c;

    assign op_in_c  = bus_op_t'(req_op);
    assign fold_c   = (state_q == S_COLLECT);
    assign wb_hit_c = wb_valid && ((wb_addr & LINE_MASK) == req_q.addr);

    snoop_combiner #(
        .NUM_SNOOPERS (NUM_SNOOPERS)
    ) u_combiner (
        .clk              (clk),
        .rst_n            (rst_n),
        .clear_i          (clear_c),
        .fold_i           (fold_c),
        .snp_valid_i      (snp_valid),
        .snp_result_i     (snp_result),
        .all_received_c_o (all_received_c),
        .combined_c_o     (combined_c)
    );

    // Next state, counter, latch and response selection
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        req_d         = req_q;
        rsp_snoop_d   = SNP_NOHIT;
        rsp_timeout_d = 1'b0;
        clear_c       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid && op_in_c != OP_NOP) begin
                    req_d.op   = op_in_c;
                    req_d.addr = req_addr & LINE_MASK;
                    clear_c    = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (req_q.op == OP_WRITE) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d   = '0;
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (all_received_c) begin
                    if (combined_c == SNP_HITM &&
                        (req_q.op == OP_READ || req_q.op == OP_RWIM)) begin
                        cnt_d   = '0;
                        state_d = S_WAIT_WB;
                    end else begin
                        rsp_snoop_d = combined_c;
                        state_d     = S_RESP;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    rsp_snoop_d   = combined_c;
                    rsp_timeout_d = 1'b1;
                    state_d       = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_WB: begin
                if (wb_hit_c) begin
                    rsp_snoop_d = SNP_HITM;
                    state_d     = S_RESP;
                end else if (cnt_q == CNT_MAX) begin
                    rsp_snoop_d   = SNP_HITM;
                    rsp_timeout_d = 1'b1;
                    state_d       = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            req_q         <= '0;
            req_ready_q   <= 1'b1;
            bus_valid_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_snoop_q   <= SNP_NOHIT;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_q         <= req_d;
            req_ready_q   <= (state_d == S_IDLE);
            bus_valid_q   <= (state_d == S_ISSUE);
            rsp_valid_q   <= (state_d == S_RESP);
            rsp_snoop_q   <= rsp_snoop_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign bus_valid   = bus_valid_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_snoop   = rsp_snoop_q;
    assign rsp_timeout = rsp_timeout_q;
    assign bus_op      = req_q.op;
    assign bus_addr    = req_q.addr;

endmodule

// File: tb/tb_bus_op_responder.sv
// Bench for bus_op_responder: directed scenarios plus randomized operations vs a cycle-count model.
module tb_bus_op_responder;

    localparam int NS   = 3;
    localparam int TMO  = 15;
    localparam int LAST = 40;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [31:0]   req_addr;
    logic          rsp_valid;
    logic [1:0]    rsp_snoop;
    logic          rsp_timeout;
    logic          bus_valid;
    logic [2:0]    bus_op;
    logic [31:0]   bus_addr;
    logic [NS-1:0] snp_valid;
    logic [2*NS-1:0] snp_result;
    logic          wb_valid;
    logic [31:0]   wb_addr;

    int total = 0;
    int bad   = 0;

    bus_op_responder #(.NUM_SNOOPERS(NS), .SNOOP_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_snoop(rsp_snoop), .rsp_timeout(rsp_timeout),
        .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr),
        .snp_valid(snp_valid), .snp_result(snp_result),
        .wb_valid(wb_valid), .wb_addr(wb_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: response cycle/result from arrival cycles (first strobe per agent counts)
    function automatic void model(input logic [2:0] op, input int arr[NS], input int res[NS],
                                  input int wb_cyc, output int e_n, output int e_cyc,
                                  output logic [1:0] e_s, output logic e_t);
        int  last, acc, wstart, r;
        bit  missing;
        e_n = 1; e_cyc = -1; e_s = 2'd0; e_t = 1'b0;
        if (op == 3'd0) begin e_n = 0; return; end
        if (op == 3'd2) begin e_cyc = 2; return; end
        last = 0; acc = 0; missing = 0;
        for (int k = 0; k < NS; k++) begin
            if (arr[k] >= 2 && arr[k] <= 2 + TMO) begin
                r = (res[k] == 3) ? 0 : res[k];
                if (arr[k] > last) last = arr[k];
                if (r > acc) acc = r;
            end else begin
                missing = 1;
            end
        end
        if (missing) begin
            e_cyc = 3 + TMO; e_s = 2'(acc); e_t = 1'b1;
        end else if (acc == 2 && (op == 3'd1 || op == 3'd4)) begin
            wstart = last + 1;
            e_s = 2'd2;
            if (wb_cyc >= wstart && wb_cyc <= wstart + TMO) e_cyc = wb_cyc + 1;
            else begin e_cyc = wstart + TMO + 1; e_t = 1'b1; end
        end else begin
            e_cyc = last + 1; e_s = 2'(acc);
        end
    endfunction

    // Drive one operation over a fixed window and record what the DUT did
    task automatic run_op(input logic [2:0] op, input logic [31:0] addr, input int arr[NS],
                          input int res[NS], input int dup_cyc, input int wb_cyc, input int bad_cyc,
                          input bit flood, output int n_rsp, output int r_cyc,
                          output logic [1:0] r_s, output logic r_t, output int bv_cyc,
                          output logic [31:0] b_addr, output logic [2:0] b_op);
        n_rsp = 0; r_cyc = -1; r_s = 2'd0; r_t = 1'b0; bv_cyc = -1; b_addr = '0; b_op = '0;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 3'd0; req_addr = $urandom;
        for (int cyc = 1; cyc <= LAST; cyc++) begin
            for (int k = 0; k < NS; k++) begin
                snp_valid[k] = flood || (arr[k] == cyc) || (k == 0 && dup_cyc == cyc);
                snp_result[2*k +: 2] = (flood || (k == 0 && dup_cyc == cyc)) ? 2'd2 : 2'(res[k]);
            end
            wb_valid = (cyc == wb_cyc) || (cyc == bad_cyc);
            wb_addr  = (cyc == wb_cyc) ? ((addr & 32'hffff_ffc0) | ($urandom & 32'h3f))
                                       : (addr ^ 32'h0000_0040);
            @(negedge clk);
            if (bus_valid && bv_cyc < 0) begin
                bv_cyc = cyc; b_addr = bus_addr; b_op = bus_op;
            end
            if (rsp_valid) begin
                n_rsp++;
                if (n_rsp == 1) begin r_cyc = cyc; r_s = rsp_snoop; r_t = rsp_timeout; end
            end
            @(posedge clk); #1;
        end
        snp_valid = '0; wb_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        total++; if ({rsp_valid, rsp_snoop, rsp_timeout, bus_valid} !== 5'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 00000", {rsp_valid, rsp_snoop, rsp_timeout, bus_valid}); end
        total++; if ({bus_op, bus_addr} !== 35'b0) begin
            bad++; $display("FAIL reset_bus: got op=%0d addr=%h want 0", bus_op, bus_addr); end
    endtask

    task automatic test_read_basic();
        int arr[NS] = '{2, 2, 2};
        int res[NS] = '{0, 0, 0};
        int n, rc, bc; logic [1:0] s; logic t; logic [31:0] ba; logic [2:0] bo;
        run_op(3'd1, 32'h0001_2345, arr, res, -1, -1, -1, 1'b0, n, rc, s, t, bc, ba, bo);
        total++; if (bc !== 1) begin bad++; $display("FAIL read_issue_cyc: got %0d want 1", bc); end
        total++; if (ba !== 32'h0001_2340) begin bad++; $display("FAIL read_bus_addr: got %h want 00012340", ba); end
        total++; if (bo !== 3'd1) begin bad++; $display("FAIL read_bus_op: got %0d want 1", bo); end
        total++; if (n !== 1 || rc !== 3) begin bad++; $display("FAIL read_rsp: got n=%0d cyc=%0d want n=1 cyc=3", n, rc); end
        total++; if (s !== 2'd0 || t !== 1'b0) begin bad++; $display("FAIL read_result: got s=%0d t=%b want s=0 t=0", s, t); end
    endtask

    task automatic test_rwim_writeback();
        int arr[NS] = '{2, 3, 4};
        int res[NS] = '{1, 0, 2};
        int n, rc, bc; logic [1:0] s; logic t; logic [31:0] ba; logic [2:0] bo;
        run_op(3'd4, 32'h0000_0000, arr, res, -1, 7, 6, 1'b0, n, rc, s, t, bc, ba, bo);
        total++; if (n !== 1 || rc !== 8) begin bad++; $display("FAIL rwim_rsp: got n=%0d cyc=%0d want n=1 cyc=8", n, rc); end
        total++; if (s !== 2'd2 || t !== 1'b0) begin bad++; $display("FAIL rwim_result: got s=%0d t=%b want s=2 t=0", s, t); end
    endtask

    task automatic test_write_flood();
        int arr[NS] = '{-1, -1, -1};
        int res[NS] = '{2, 2, 2};
        int n, rc, bc; logic [1:0] s; logic t; logic [31:0] ba; logic [2:0] bo;
        run_op(3'd2, 32'h8000_0000, arr, res, -1, -1, -1, 1'b1, n, rc, s, t, bc, ba, bo);
        total++; if (n !== 1 || rc !== 2) begin bad++; $display("FAIL write_rsp: got n=%0d cyc=%0d want n=1 cyc=2", n, rc); end
        total++; if (s !== 2'd0 || t !== 1'b0) begin bad++; $display("FAIL write_result: got s=%0d t=%b want s=0 t=0", s, t); end
        total++; if (ba !== 32'h8000_0000 || bo !== 3'd2) begin bad++; $display("FAIL write_bus: got op=%0d addr=%h want 2 80000000", bo, ba); end
    endtask

    task automatic test_timeout();
        int arr[NS] = '{2, 3, -1};
        int res[NS] = '{1, 0, 0};
        int n, rc, bc; logic [1:0] s; logic t; logic [31:0] ba; logic [2:0] bo;
        run_op(3'd1, 32'h0000_3000, arr, res, -1, -1, -1, 1'b0, n, rc, s, t, bc, ba, bo);
        total++; if (n !== 1 || rc !== 3 + TMO) begin bad++; $display("FAIL timeout_rsp: got n=%0d cyc=%0d want n=1 cyc=%0d", n, rc, 3 + TMO); end
        total++; if (s !== 2'd1 || t !== 1'b1) begin bad++; $display("FAIL timeout_result: got s=%0d t=%b want s=1 t=1", s, t); end
    endtask

    task automatic test_inval_dup();
        int arr[NS] = '{2, 4, 4};
        int res[NS] = '{2, 0, 0};
        int n, rc, bc; logic [1:0] s; logic t; logic [31:0] ba; logic [2:0] bo;
        run_op(3'd3, 32'h0000_5040, arr, res, 3, 6, -1, 1'b0, n, rc, s, t, bc, ba, bo);
        total++; if (n !== 1 || rc !== 5) begin bad++; $display("FAIL inval_rsp: got n=%0d cyc=%0d want n=1 cyc=5", n, rc); end
        total++; if (s !== 2'd2 || t !== 1'b0) begin bad++; $display("FAIL inval_result: got s=%0d t=%b want s=2 t=0", s, t); end
    endtask

    task automatic test_reset_mid();
        int arr[NS] = '{2, 2, 3};
        int res[NS] = '{1, 0, 0};
        int n, rc, bc; logic [1:0] s; logic t; logic [31:0] ba; logic [2:0] bo;
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd1; req_addr = 32'h1234_5678;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 3'd0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (req_ready !== 1'b1 || bus_valid !== 1'b0 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL midrst_ctrl: got rdy=%b bv=%b rv=%b want 1 0 0", req_ready, bus_valid, rsp_valid); end
        total++; if (bus_op !== 3'd0 || bus_addr !== 32'd0 || rsp_snoop !== 2'd0 || rsp_timeout !== 1'b0) begin
            bad++; $display("FAIL midrst_data: got op=%0d addr=%h s=%0d t=%b want 0", bus_op, bus_addr, rsp_snoop, rsp_timeout); end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd1, 32'h0000_7788, arr, res, -1, -1, -1, 1'b0, n, rc, s, t, bc, ba, bo);
        total++; if (n !== 1 || rc !== 4 || s !== 2'd1 || t !== 1'b0) begin
            bad++; $display("FAIL midrst_after: got n=%0d cyc=%0d s=%0d t=%b want 1 4 1 0", n, rc, s, t); end
    endtask

    task automatic test_random();
        int arr[NS]; int res[NS];
        int dup, wbc, badc, n, rc, bc, e_n, e_cyc;
        logic [1:0] s, e_s; logic t, e_t, flood; logic [31:0] ba, addr; logic [2:0] bo, op;
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 9))
                0:       op = 3'd0;
                1, 2:    op = 3'd2;
                3, 4:    op = 3'd3;
                5, 6:    op = 3'd4;
                default: op = 3'd1;
            endcase
            addr = $urandom;
            for (int k = 0; k < NS; k++) begin
                arr[k] = ($urandom_range(0, 11) == 0) ? -1 : int'($urandom_range(2, 7));
                res[k] = int'($urandom_range(0, 3));
            end
            dup   = (arr[0] > 0 && $urandom_range(0, 1) == 1) ? arr[0] + int'($urandom_range(1, 3)) : -1;
            wbc   = int'($urandom_range(3, 30));
            badc  = int'($urandom_range(2, 30));
            flood = (op == 3'd2) ? 1'($urandom_range(0, 1)) : 1'b0;
            model(op, arr, res, wbc, e_n, e_cyc, e_s, e_t);
            run_op(op, addr, arr, res, dup, wbc, badc, flood, n, rc, s, t, bc, ba, bo);
            total++; if (n !== e_n) begin bad++; $display("FAIL rand%0d_count: got %0d want %0d", it, n, e_n); end
            if (e_n == 1) begin
                total++; if (rc !== e_cyc) begin bad++; $display("FAIL rand%0d_cyc: op=%0d got %0d want %0d", it, op, rc, e_cyc); end
                total++; if (s !== e_s || t !== e_t) begin bad++; $display("FAIL rand%0d_result: got s=%0d t=%b want s=%0d t=%b", it, s, t, e_s, e_t); end
                total++; if (bc !== 1 || ba !== (addr & 32'hffff_ffc0) || bo !== op) begin
                    bad++; $display("FAIL rand%0d_bus: got cyc=%0d op=%0d addr=%h want 1 %0d %h", it, bc, bo, ba, op, addr & 32'hffff_ffc0); end
            end else begin
                total++; if (bc !== -1) begin bad++; $display("FAIL rand%0d_nop_issue: got %0d want -1", it, bc); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0;
        snp_valid = '0; snp_result = '0; wb_valid = 1'b0; wb_addr = '0;
        test_reset();
        test_read_basic();
        test_rwim_writeback();
        test_write_flood();
        test_timeout();
        test_inval_dup();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
